// File: rtl/fetch_buffer.sv
// Fetch-to-decode instruction queue: circular FIFO of (pc, instr) pairs
// with first-word fall-through, flush on redirect and stall counting.
module fetch_buffer #(
  parameter int DEPTH   = 4,
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32,
  parameter int CNT_W   = 16,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [CW-1:0]      count,
  output logic [CNT_W-1:0]   stall_cycles
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [PC_W-1:0]    pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          stall;

  // in_ready looks only at stored state, never at out_ready
  assign in_ready  = (count < FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  assign stall     = in_valid & ~in_ready & ~flush;

  assign out_pc    = out_valid ? pc_mem[rd_ptr]    : '0;
  assign out_instr = out_valid ? instr_mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= in_pc;
      instr_mem[wr_ptr] <= in_instr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
    end else if (stall && stall_cycles != '1) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed self-checking bench for fetch_buffer.
// One task per scenario; inputs change 1ns after the rising edge.
module tb_fetch_buffer;

  localparam int DEPTH   = 4;
  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;
  localparam int CNT_W   = 16;
  localparam int CW      = $clog2(DEPTH + 1);

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [PC_W-1:0]    in_pc;
  logic [INSTR_W-1:0] in_instr;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [PC_W-1:0]    out_pc;
  logic [INSTR_W-1:0] out_instr;
  logic [CW-1:0]      count;
  logic [CNT_W-1:0]   stall_cycles;

  int errors = 0;
  int checks = 0;

  fetch_buffer #(
    .DEPTH(DEPTH), .PC_W(PC_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr),
    .count(count), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0;
    flush = 1'b0; out_ready = 1'b1;
    #12;
    rst = 1'b1;
    tick(); tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    checks++;
    if (out_pc !== 32'h0) begin
      errors++; $display("FAIL reset_out_pc: got %h want 0", out_pc);
    end
    checks++;
    if (count !== 3'd0) begin
      errors++; $display("FAIL reset_count: got %0d want 0", count);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    checks++;
    if (stall_cycles !== 16'd0) begin
      errors++; $display("FAIL reset_stall: got %0d want 0", stall_cycles);
    end
  endtask

  task automatic test_fill_stall();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_pc = 32'(4 * i); in_instr = 32'(32'hA0 + i);
      tick();
    end
    checks++;
    if (count !== 3'd4) begin
      errors++; $display("FAIL full_count: got %0d want 4", count);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL full_in_ready: got %b want 0", in_ready);
    end
    in_pc = 32'h10; in_instr = 32'hA4;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (stall_cycles !== 16'd3) begin
      errors++; $display("FAIL stall_count: got %0d want 3", stall_cycles);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'(4 * i)
          || out_instr !== 32'(32'hA0 + i)) begin
        errors++;
        $display("FAIL drain_order[%0d]: got v=%b pc=%h ins=%h want pc=%h ins=%h",
                 i, out_valid, out_pc, out_instr, 32'(4 * i), 32'(32'hA0 + i));
      end
      tick();
    end
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL drain_empty: got count=%0d v=%b want 0 0",
                         count, out_valid);
    end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_pc = 32'(32'h200 + 4 * i); in_instr = 32'(32'hB0 + i);
      tick();
      checks++;
      if (out_pc !== 32'(32'h200 + 4 * i) || out_instr !== 32'(32'hB0 + i)
          || count !== 3'd1) begin
        errors++;
        $display("FAIL stream[%0d]: got pc=%h ins=%h cnt=%0d want pc=%h ins=%h cnt=1",
                 i, out_pc, out_instr, count, 32'(32'h200 + 4 * i), 32'(32'hB0 + i));
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (count !== 3'd0) begin
      errors++; $display("FAIL stream_end_count: got %0d want 0", count);
    end
  endtask

  task automatic test_back_to_back();
    logic [PC_W-1:0] exp_pc [3];
    exp_pc[0] = 32'h34; exp_pc[1] = 32'h38; exp_pc[2] = 32'h20;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_pc = 32'(32'h30 + 4 * i); in_instr = 32'(32'hC0 + i);
      tick();
    end
    in_pc = 32'h20; in_instr = 32'hC9; out_ready = 1'b1;
    tick();
    checks++;
    if (count !== 3'd3 || out_pc !== 32'h34) begin
      errors++; $display("FAIL push_pop: got cnt=%0d pc=%h want cnt=3 pc=34",
                         count, out_pc);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_pc !== exp_pc[i]) begin
        errors++; $display("FAIL push_pop_drain[%0d]: got %h want %h",
                           i, out_pc, exp_pc[i]);
      end
      tick();
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_pc = 32'(32'h50 + 4 * i); in_instr = 32'(32'hD0 + i);
      tick();
    end
    flush = 1'b1; in_pc = 32'h40; in_instr = 32'hD9; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_empty: got cnt=%0d v=%b want 0 0",
                         count, out_valid);
    end
    checks++;
    if (stall_cycles !== 16'd3) begin
      errors++; $display("FAIL flush_keeps_stall: got %0d want 3", stall_cycles);
    end
    in_valid = 1'b1; in_pc = 32'h44; in_instr = 32'hDA;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_pc !== 32'h44 || out_instr !== 32'hDA || count !== 3'd1) begin
      errors++; $display("FAIL flush_next: got pc=%h ins=%h cnt=%0d want 44 da 1",
                         out_pc, out_instr, count);
    end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_pc = 32'(32'h60 + 4 * i); in_instr = 32'(32'hE0 + i);
      tick();
    end
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || count !== 3'd0 || stall_cycles !== 16'd0) begin
      errors++; $display("FAIL async_reset: got v=%b cnt=%0d stall=%0d want 0 0 0",
                         out_valid, count, stall_cycles);
    end
    #1 rst = 1'b1;
    tick();
    in_valid = 1'b1; in_pc = 32'h100; in_instr = 32'hF0;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_pc !== 32'h100 || out_instr !== 32'hF0 || count !== 3'd1) begin
      errors++; $display("FAIL after_reset: got pc=%h ins=%h cnt=%0d want 100 f0 1",
                         out_pc, out_instr, count);
    end
  endtask

  initial begin
    test_reset();
    test_fill_stall();
    test_stream();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Instruction fetch queue between the program-counter/instruction-ROM stage and decode.
- Captures (PC, instruction) pairs produced each cycle by fetch and holds them in a small circular FIFO.
- Presents them to decode with a valid/ready handshake, so decode stalls back-pressure fetch instead of losing instructions.
- Supports a single-cycle flush on taken branch/jump, discarding all wrong-path entries.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- PC_W, 32, width of captured program counter.
- INSTR_W, 32, width of captured instruction word.
- CNT_W, 16, width of saturating stall-cycle counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset; 0 clears state immediately, release is synchronous to clk.
- in_valid  in  1  fetch presents a valid (PC, instruction) pair this cycle.
- in_ready  out  1  buffer accepts a pair this cycle.
- in_pc  in  PC_W  PC of the incoming instruction.
- in_instr  in  INSTR_W  instruction word read from ROM at in_pc.
- flush  in  1  discard all stored entries and any push/pop this cycle.
- out_valid  out  1  head entry available to decode.
- out_ready  in  1  decode consumes head entry this cycle.
- out_pc  out  PC_W  PC of head entry.
- out_instr  out  INSTR_W  instruction of head entry.
- count  out  $clog2(DEPTH+1)  number of stored entries.
- stall_cycles  out  CNT_W  saturating count of cycles with in_valid=1 and in_ready=0.

Behaviour:
- Reset (rst=0, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0, stall_cycles=0.
  - Outputs: out_valid=0, out_pc=0, out_instr=0, in_ready=1.
  - Storage array is not reset.
  - Reset asserted mid-operation drops all entries immediately; no partial state survives.
- Push = in_valid & in_ready & ~flush.
  - Writes {in_pc, in_instr} to entry wr_ptr at the clock edge; wr_ptr increments modulo DEPTH.
- Pop = out_valid & out_ready & ~flush.
  - rd_ptr increments modulo DEPTH at the clock edge.
- in_ready = (count < DEPTH), registered-state only.
  - No combinational path from out_ready to in_ready.
  - When full, a simultaneous pop does NOT enable a push in the same cycle.
- First-word fall-through:
  - out_valid = (count != 0).
  - out_pc/out_instr = entry[rd_ptr] while out_valid=1, forced to 0 while out_valid=0.
  - A pair pushed in cycle N appears on the outputs in cycle N+1 (latency 1).
- Count update: push only → +1; pop only → −1; push and pop together → unchanged (pointers both advance).
- Count never exceeds DEPTH and never underflows.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally; full/empty are decided by count, not pointer equality.
- Flush (synchronous, highest priority below reset):
  - Next edge: wr_ptr=0, rd_ptr=0, count=0.
  - In-cycle push and pop are both suppressed, even if handshakes complete.
  - out_valid=0 from the cycle after flush.
  - in_ready may be 1 during the flush cycle, but the data is discarded.
  - Flush while empty is a no-op apart from the pointer reset.
- Stall counter:
  - Increments by 1 in every cycle with in_valid=1, in_ready=0 and flush=0.
  - Saturates at 2^CNT_W−1.
  - Cleared only by reset, not by flush.
- Protocol requirement on fetch: while in_valid=1 and in_ready=0, in_pc/in_instr are held stable; the buffer does not check this.
- Decode may drop out_ready at any time; the head entry remains unchanged until popped or flushed.

Test Plan:
- Reset then idle, out_ready=1: out_valid=0, out_pc=0, count=0, in_ready=1, stall_cycles=0.
- Push pc 0x00,0x04,0x08,0x0C (instr 0xA0..0xA3) with out_ready=0:
  - count reaches 4 and in_ready=0.
  - Holding in_valid for 3 more cycles gives stall_cycles=3.
  - Then out_ready=1 pops 0x00,0x04,0x08,0x0C in order.
- Continuous stream of 10 pushes with out_ready=1 every cycle:
  - Each pc appears on out_pc exactly one cycle after its push.
  - count stays at 1; pointers wrap past DEPTH without loss or duplication.
- Fill 3 entries, then push pc 0x20 and pop in the same cycle: count stays 3, and head advances to the second entry.
- Fill 3 entries, then assert flush together with in_valid=1 (pc 0x40) and out_ready=1:
  - Next cycle count=0 and out_valid=0, and pc 0x40 is not stored.
  - A following push of 0x44 is the next output.
- Fill 2 entries and pull rst low asynchronously between edges:
  - out_valid=0 and count=0 immediately.
  - After release, the first push of pc 0x100 is the first output.
